// File: rtl/mem_port_ctrl_if.sv
// Bundle of fetch, load/store, RAM-side and counter signals around mem_port_ctrl.
// The slave modport is the controller; the master modport is the requesters plus RAM.
interface mem_port_ctrl_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_valid;
  logic [DATA_W-1:0] if_rdata;

  logic              ls_req;
  logic              ls_we;
  logic [ADDR_W-1:0] ls_addr;
  logic [DATA_W-1:0] ls_wdata;
  logic              ls_gnt;
  logic              ls_valid;
  logic [DATA_W-1:0] ls_rdata;

  logic [ADDR_W-1:0] ram_addr_1;
  logic [ADDR_W-1:0] ram_addr_2;
  logic [DATA_W-1:0] ram_wdata;
  logic              ram_we;
  logic [DATA_W-1:0] ram_rdata_1;
  logic [DATA_W-1:0] ram_rdata_2;

  logic [7:0]        rd_count;
  logic [7:0]        wr_count;

  modport slave (
    input  if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, ram_rdata_1, ram_rdata_2,
    output if_valid, if_rdata, ls_gnt, ls_valid, ls_rdata,
    output ram_addr_1, ram_addr_2, ram_wdata, ram_we, rd_count, wr_count
  );

  modport master (
    output if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, ram_rdata_1, ram_rdata_2,
    input  if_valid, if_rdata, ls_gnt, ls_valid, ls_rdata,
    input  ram_addr_1, ram_addr_2, ram_wdata, ram_we, rd_count, wr_count
  );
endinterface

// File: rtl/mem_port_ctrl.sv
// Two-port RAM front end: always-ready fetch channel on port 1, and a
// one-outstanding load/store FSM on port 2 with store-to-fetch forwarding.
module mem_port_ctrl #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
) (
  input logic            clk,
  input logic            reset,
  mem_port_ctrl_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StRdWait, StWrAck} state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] addr2_q;
  logic [DATA_W-1:0] wdata_q;
  logic              if_valid_q;
  logic              fwd_q;
  logic [DATA_W-1:0] fwd_data_q;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] ls_rdata_q;
  logic [7:0]        rd_count_q;
  logic [7:0]        wr_count_q;

  logic              gnt;
  logic              st_gnt;
  logic              fwd_hit;
  logic              ls_valid_cur;
  logic [DATA_W-1:0] if_rdata_cur;
  logic [DATA_W-1:0] ls_rdata_cur;

  always_comb begin
    gnt          = bus.ls_req & (state_q == StIdle) & ~reset;
    st_gnt       = gnt & bus.ls_we;
    // A store landing this cycle is invisible to port 1's read, so capture it.
    fwd_hit      = bus.if_req & st_gnt & (bus.if_addr == bus.ls_addr);
    if_rdata_cur = if_valid_q ? (fwd_q ? fwd_data_q : bus.ram_rdata_1) : if_rdata_q;
    // Gating with reset drops a response whose completion cycle is a reset cycle.
    ls_valid_cur = (state_q != StIdle) & ~reset;
    ls_rdata_cur = ls_rdata_q;
    unique case (state_q)
      StRdWait: ls_rdata_cur = bus.ram_rdata_2;
      StWrAck:  ls_rdata_cur = '0;
      default:  ls_rdata_cur = ls_rdata_q;
    endcase
  end

  assign bus.ram_addr_1 = bus.if_addr;
  assign bus.ram_addr_2 = gnt ? bus.ls_addr : addr2_q;
  assign bus.ram_wdata  = st_gnt ? bus.ls_wdata : wdata_q;
  assign bus.ram_we     = st_gnt;
  assign bus.ls_gnt     = gnt;
  assign bus.if_valid   = if_valid_q;
  assign bus.if_rdata   = if_rdata_cur;
  assign bus.ls_valid   = ls_valid_cur;
  assign bus.ls_rdata   = ls_rdata_cur;
  assign bus.rd_count   = rd_count_q;
  assign bus.wr_count   = wr_count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      addr2_q    <= '0;
      wdata_q    <= '0;
      if_valid_q <= 1'b0;
      fwd_q      <= 1'b0;
      fwd_data_q <= '0;
      if_rdata_q <= '0;
      ls_rdata_q <= '0;
      rd_count_q <= '0;
      wr_count_q <= '0;
    end else begin
      if_valid_q <= bus.if_req;
      fwd_q      <= fwd_hit;
      if (fwd_hit)    fwd_data_q <= bus.ls_wdata;
      if (if_valid_q) if_rdata_q <= if_rdata_cur;
      if (gnt)        addr2_q    <= bus.ls_addr;
      if (st_gnt)     wdata_q    <= bus.ls_wdata;

      unique case (state_q)
        StIdle: begin
          if (gnt) state_q <= bus.ls_we ? StWrAck : StRdWait;
        end
        StRdWait: begin
          ls_rdata_q <= bus.ram_rdata_2;
          if (rd_count_q != 8'hFF) rd_count_q <= rd_count_q + 8'd1;
          state_q <= StIdle;
        end
        StWrAck: begin
          ls_rdata_q <= '0;
          if (wr_count_q != 8'hFF) wr_count_q <= wr_count_q + 8'd1;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_ctrl.sv
// Scoreboard bench for mem_port_ctrl: stimulus pushes expected responses, a
// negedge monitor pops and compares whenever if_valid or ls_valid is presented.
module tb_mem_port_ctrl;
  localparam int unsigned AW = 8;
  localparam int unsigned DW = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mem_port_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
  mem_port_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (.clk(clk), .reset(reset), .bus(bus));

  // Registered dual-port RAM model; preloaded on the first clock edge.
  logic [7:0] mem [256];
  logic       loaded = 1'b0;
  always @(posedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
      mem[8'h10] <= 8'h5A;
      mem[8'h01] <= 8'h11;
      mem[8'h02] <= 8'h22;
      mem[8'h03] <= 8'h33;
      mem[8'h04] <= 8'h44;
      loaded <= 1'b1;
    end else if (bus.ram_we) begin
      mem[bus.ram_addr_2] <= bus.ram_wdata;
    end
    bus.ram_rdata_1 <= mem[bus.ram_addr_1];
    bus.ram_rdata_2 <= mem[bus.ram_addr_2];
  end

  int n_tests = 0;
  int n_fail = 0;
  logic [7:0] if_exp_q[$];
  logic [7:0] ls_exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset === 1'b0) begin
      if (bus.if_valid === 1'b1) begin
        if (if_exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL if_unexpected: if_valid=1 rdata=0x%0h with nothing pending",
                   bus.if_rdata);
        end else check("if_rdata", {24'd0, bus.if_rdata}, {24'd0, if_exp_q.pop_front()});
      end
      if (bus.ls_valid === 1'b1) begin
        if (ls_exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL ls_unexpected: ls_valid=1 rdata=0x%0h with nothing pending",
                   bus.ls_rdata);
        end else check("ls_rdata", {24'd0, bus.ls_rdata}, {24'd0, ls_exp_q.pop_front()});
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic ls_op(input logic we, input logic [7:0] a, input logic [7:0] wd,
                       input logic [7:0] exp);
    int t;
    t = 0;
    bus.ls_req = 1'b1;
    bus.ls_we = we;
    bus.ls_addr = a;
    bus.ls_wdata = wd;
    @(negedge clk);
    while (bus.ls_gnt !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (bus.ls_gnt !== 1'b1) begin
      n_tests++;
      n_fail++;
      $display("FAIL ls_gnt_timeout: no grant within 20 cycles for addr 0x%0h", a);
    end else ls_exp_q.push_back(exp);
    cyc();
    bus.ls_req = 1'b0;
  endtask

  task automatic fetch(input logic [7:0] a, input logic [7:0] exp);
    bus.if_req = 1'b1;
    bus.if_addr = a;
    if_exp_q.push_back(exp);
    cyc();
    bus.if_req = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] pat;
    logic [6:0] exp_pat;
    logic [7:0] la [4];
    logic [7:0] ld [4];
    int k;
    bit g;

    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.ls_req = 1'b0; bus.ls_we = 1'b0; bus.ls_addr = '0; bus.ls_wdata = '0;

    // Reset: requests during reset are neither granted nor answered.
    repeat (2) cyc();
    bus.if_req = 1'b1; bus.if_addr = 8'h10; bus.ls_req = 1'b1;
    @(negedge clk);
    check("gnt_in_reset", {31'd0, bus.ls_gnt}, 32'd0);
    check("we_in_reset", {31'd0, bus.ram_we}, 32'd0);
    cyc();
    reset = 1'b0; bus.if_req = 1'b0; bus.ls_req = 1'b0;
    @(negedge clk);
    check("fetch_in_reset", {31'd0, bus.if_valid}, 32'd0);
    check("rst_ls_valid", {31'd0, bus.ls_valid}, 32'd0);
    check("rst_rd_count", {24'd0, bus.rd_count}, 32'd0);
    check("rst_wr_count", {24'd0, bus.wr_count}, 32'd0);
    check("rst_if_rdata", {24'd0, bus.if_rdata}, 32'd0);
    check("rst_ls_rdata", {24'd0, bus.ls_rdata}, 32'd0);
    cyc();

    // Single load of RAM[0x10].
    ls_op(1'b0, 8'h10, 8'h00, 8'h5A);
    cyc();
    @(negedge clk);
    check("rd_count_1", {24'd0, bus.rd_count}, 32'd1);
    cyc();

    // Store 0x33 to 0x20, then load it back.
    bus.ls_req = 1'b1; bus.ls_we = 1'b1; bus.ls_addr = 8'h20; bus.ls_wdata = 8'h33;
    @(negedge clk);
    check("st_gnt", {31'd0, bus.ls_gnt}, 32'd1);
    check("st_we", {31'd0, bus.ram_we}, 32'd1);
    check("st_addr2", {24'd0, bus.ram_addr_2}, 32'h20);
    check("st_wdata", {24'd0, bus.ram_wdata}, 32'h33);
    ls_exp_q.push_back(8'h00);
    cyc();
    bus.ls_req = 1'b0;
    @(negedge clk);
    check("st_we_one_cycle", {31'd0, bus.ram_we}, 32'd0);
    check("st_ack_valid", {31'd0, bus.ls_valid}, 32'd1);
    cyc();
    ls_op(1'b0, 8'h20, 8'h00, 8'h33);
    cyc();
    @(negedge clk);
    check("rd_count_2", {24'd0, bus.rd_count}, 32'd2);
    check("wr_count_1", {24'd0, bus.wr_count}, 32'd1);
    cyc();

    // Fetches: single, then back-to-back; data holds once valid drops.
    fetch(8'h10, 8'h5A);
    cyc();
    fetch(8'h01, 8'h11);
    fetch(8'h02, 8'h22);
    cyc();
    @(negedge clk);
    check("if_valid_drop", {31'd0, bus.if_valid}, 32'd0);
    check("if_rdata_hold", {24'd0, bus.if_rdata}, 32'h22);
    cyc();

    // Same-cycle store and fetch to 0x40 forwards the store data.
    bus.ls_req = 1'b1; bus.ls_we = 1'b1; bus.ls_addr = 8'h40; bus.ls_wdata = 8'h77;
    bus.if_req = 1'b1; bus.if_addr = 8'h40;
    @(negedge clk);
    check("fwd_gnt", {31'd0, bus.ls_gnt}, 32'd1);
    ls_exp_q.push_back(8'h00);
    if_exp_q.push_back(8'h77);
    cyc();
    bus.ls_req = 1'b0; bus.if_req = 1'b0;
    cyc();
    fetch(8'h40, 8'h77);
    cyc();

    // Held request for four loads: grant every other cycle.
    la[0] = 8'h01; la[1] = 8'h02; la[2] = 8'h03; la[3] = 8'h04;
    ld[0] = 8'h11; ld[1] = 8'h22; ld[2] = 8'h33; ld[3] = 8'h44;
    exp_pat = 7'b1010101;
    pat = '0;
    k = 0;
    bus.ls_req = 1'b1; bus.ls_we = 1'b0; bus.ls_addr = la[0];
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      g = (bus.ls_gnt === 1'b1);
      pat[6-i] = g;
      if (g && k < 4) begin
        ls_exp_q.push_back(ld[k]);
        k++;
      end
      cyc();
      if (g) begin
        if (k < 4) bus.ls_addr = la[k];
        else bus.ls_req = 1'b0;
      end
    end
    bus.ls_req = 1'b0;
    check("gnt_pattern", {25'd0, pat}, {25'd0, exp_pat});
    cyc();
    @(negedge clk);
    check("rd_count_6", {24'd0, bus.rd_count}, 32'd6);
    cyc();

    // Reset while a load is pending drops its response.
    bus.ls_req = 1'b1; bus.ls_we = 1'b0; bus.ls_addr = 8'h10;
    @(negedge clk);
    check("rst_load_gnt", {31'd0, bus.ls_gnt}, 32'd1);
    cyc();
    reset = 1'b1;
    @(negedge clk);
    check("rst_drop_valid", {31'd0, bus.ls_valid}, 32'd0);
    check("rst_drop_gnt", {31'd0, bus.ls_gnt}, 32'd0);
    cyc();
    reset = 1'b0;
    @(negedge clk);
    check("gnt_after_reset", {31'd0, bus.ls_gnt}, 32'd1);
    check("rst_drop_ls_valid", {31'd0, bus.ls_valid}, 32'd0);
    check("rst_drop_rd_count", {24'd0, bus.rd_count}, 32'd0);
    check("rst_drop_wr_count", {24'd0, bus.wr_count}, 32'd0);
    if (bus.ls_gnt === 1'b1) ls_exp_q.push_back(8'h5A);
    cyc();
    bus.ls_req = 1'b0;
    cyc();
    @(negedge clk);
    check("rd_count_after_rst", {24'd0, bus.rd_count}, 32'd1);
    cyc();

    // 300 stores saturate wr_count at 255.
    for (int i = 0; i < 300; i++) ls_op(1'b1, 8'h80, i[7:0], 8'h00);
    cyc();
    @(negedge clk);
    check("wr_count_sat", {24'd0, bus.wr_count}, 32'd255);
    check("rd_count_untouched", {24'd0, bus.rd_count}, 32'd1);
    repeat (3) cyc();
    @(negedge clk);
    check("wr_count_hold", {24'd0, bus.wr_count}, 32'd255);

    repeat (3) cyc();
    check("if_queue_drained", if_exp_q.size(), 32'd0);
    check("ls_queue_drained", ls_exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
